key_event_ctrl: RTL

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/key_evt_fifo.sv | 54 +++++
 rtl/key_event_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 scan-byte to key-event path:
// fetch FSM encoding, prefix bytes and the key event record.
package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_GAP  = 2'd2
  } kbd_state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_REL = 8'hF0;
  localparam int         EVT_W   = 10;

  // Packed as {ext, rel, code}; this is also the FIFO word layout.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PFX_EXT) || (b == PFX_REL);
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Power-of-two event FIFO; pointers wrap naturally, count carries one extra bit
// so full and empty are distinguishable.
module key_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Pulls scan bytes from the PS/2 byte buffer, folds E0/F0 prefixes into
// key events, optionally filters typematic repeats and queues the events.
module key_event_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int REPEAT_FILTER = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  input  logic       ev_ready,
  output logic [7:0] drop_cnt,
  output logic       ovf_seen
);

  localparam bit FILTER_ON = (REPEAT_FILTER != 0);

  // Handshakes: a byte is taken on the edge where IDLE && en && ready, and the
  // buffer is told to advance by nextdata_n low for the single following cycle.
  // An event leaves on every edge where ev_valid && ev_ready; ev_ready is a
  // don't-care while ev_valid is low.
  kbd_state_t state;
  kbd_state_t state_nx;
  logic       fetch;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fetch      = 1'b0;
    nextdata_n = 1'b1;
    case (state)
      ST_IDLE: begin
        if (en && ready) begin
          state_nx = ST_POP;
          fetch    = 1'b1;
        end
      end
      ST_POP: begin
        nextdata_n = 1'b0;
        state_nx   = ST_GAP;
      end
      ST_GAP:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  logic       ext_pend;
  logic       rel_pend;
  logic       held_valid;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;
  logic       repeat_make;
  logic       evt_push;
  logic       evt_pop;
  key_evt_t   cur_evt;

  assign cur_evt     = '{ext: ext_pend, rel: rel_pend, code: data};
  assign held_match  = held_valid && (held_ext == ext_pend) && (held_code == data);
  assign repeat_make = FILTER_ON && !rel_pend && held_match;
  assign evt_push    = fetch && !is_prefix(data) && !repeat_make;
  assign evt_pop     = ev_valid && ev_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_pend   <= 1'b0;
      rel_pend   <= 1'b0;
      held_valid <= 1'b0;
      held_ext   <= 1'b0;
      held_code  <= 8'h00;
    end else if (fetch) begin
      if (data == PFX_EXT) begin
        ext_pend <= 1'b1;
      end else if (data == PFX_REL) begin
        rel_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
        // Releasing some other key leaves the held key alone.
        if (rel_pend) begin
          if (held_match) held_valid <= 1'b0;
        end else begin
          held_valid <= 1'b1;
          held_ext   <= ext_pend;
          held_code  <= data;
        end
      end
    end
  end

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  key_evt_t                head;

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (evt_push),
    .din   (cur_evt),
    .pop   (evt_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ev_valid = (fifo_count != '0);
  assign ev_code  = fifo_empty ? 8'h00 : head.code;
  assign ev_ext   = fifo_empty ? 1'b0  : head.ext;
  assign ev_rel   = fifo_empty ? 1'b0  : head.rel;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      drop_cnt <= 8'h00;
      ovf_seen <= 1'b0;
    end else begin
      if (overflow) ovf_seen <= 1'b1;
      if (evt_push && fifo_full && !evt_pop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
